// File: rtl/simon_pkg.sv
// Shared Simon game types: button count, button-number type and input FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package simon_pkg;

   localparam int NUM_BUTTONS = 4;

   // Button number as seen by the Simon game controller
   typedef logic [1:0] buttonNum_t;

   // Player input FSM states
   typedef enum logic [1:0] {
      WAIT_CLEAR = 2'd0,
      ARMED      = 2'd1,
      HELD       = 2'd2
   } inputState_t;

   // Number of set bits in a button vector
   function automatic logic [2:0] countOnes(input logic [NUM_BUTTONS-1:0] vec);
      logic [2:0] total;
      total = 3'd0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         total = total + {2'd0, vec[i]};
      end
      return total;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// One-button conditioner: 2-flop synchroniser followed by a stable-level debounce counter.
// Latency: a raw change held from edge 0 appears on stableLevel at edge DEBOUNCE_CYCLES+2.
// Backpressure: none; free-running on every clock.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic btnRaw,
   output logic stableLevel,
   output logic quiet
);

   localparam logic [7:0] DEBOUNCE_LIMIT = 8'(DEBOUNCE_CYCLES);

   logic       syncFirst;
   logic       syncSecond;
   logic [7:0] bounceCount;

   // Bring the asynchronous button into the clock domain
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         syncFirst  <= 1'b0;
         syncSecond <= 1'b0;
      end else begin
         syncFirst  <= btnRaw;
         syncSecond <= syncFirst;
      end
   end

   // Count consecutive cycles of disagreement; flip the stable level once the count is met
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stableLevel <= 1'b0;
         bounceCount <= 8'd0;
      end else if (syncSecond == stableLevel) begin
         bounceCount <= 8'd0;
      end else if (bounceCount == DEBOUNCE_LIMIT) begin
         stableLevel <= ~stableLevel;
         bounceCount <= 8'd0;
      end else begin
         bounceCount <= bounceCount + 8'd1;
      end
   end

   // Nothing in flight: both sync stages agree with the stable level and no count is pending.
   // Lets the FSM tell a genuinely released button from one still ramping up after reset.
   assign quiet = (syncFirst == stableLevel) && (syncSecond == stableLevel) && (bounceCount == 8'd0);

endmodule

// File: rtl/simon_button_input.sv
// Simon player input: debounces four buttons and delivers one clean encoded press per press/release.
// Latency: raw press or release to player_pressed change is DEBOUNCE_CYCLES+3 edges.
// Backpressure: none; enable only gates acceptance of new presses, never aborts one in progress.
module simon_button_input
   import simon_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [NUM_BUTTONS-1:0] btn_raw,
   output buttonNum_t             player_num,
   output logic                   player_pressed,
   output logic                   press_pulse,
   output logic                   multi_press
);

   logic [NUM_BUTTONS-1:0] btnStable;
   logic [NUM_BUTTONS-1:0] btnQuiet;
   logic [2:0]             downCount;
   buttonNum_t             downIndex;
   logic                   allQuiet;
   logic                   primed;

   inputState_t state, stateNext;
   buttonNum_t  numNext;
   logic        pressedNext;
   logic        pulseNext;
   logic        multiNext;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BUTTONS; gi++) begin : gButton
         button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) uDebounce (
            .clk        (clk),
            .reset      (reset),
            .btnRaw     (btn_raw[gi]),
            .stableLevel(btnStable[gi]),
            .quiet      (btnQuiet[gi])
         );
      end
   endgenerate

   // Popcount and one-hot-to-binary encode of the debounced buttons
   always_comb begin
      downCount = countOnes(btnStable);
      allQuiet  = &btnQuiet;
      downIndex = '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         if (btnStable[i]) begin
            downIndex = buttonNum_t'(i);
         end
      end
   end

   // Blocks arming on the first edge after reset, before the synchroniser has sampled the pins
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         primed <= 1'b0;
      end else begin
         primed <= 1'b1;
      end
   end

   // FSM state and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= WAIT_CLEAR;
         player_num     <= '0;
         player_pressed <= 1'b0;
         press_pulse    <= 1'b0;
         multi_press    <= 1'b0;
      end else begin
         state          <= stateNext;
         player_num     <= numNext;
         player_pressed <= pressedNext;
         press_pulse    <= pulseNext;
         multi_press    <= multiNext;
      end
   end

   // Next state: arm on all-clear, accept a single press, follow it to its release
   always_comb begin
      stateNext   = state;
      numNext     = player_num;
      pressedNext = player_pressed;
      pulseNext   = 1'b0;
      multiNext   = 1'b0;
      case (state)
         WAIT_CLEAR: begin
            pressedNext = 1'b0;
            if (primed && (btnStable == '0) && allQuiet) begin
               stateNext = ARMED;
            end
         end
         ARMED: begin
            if (downCount == 3'd0) begin
               stateNext = ARMED;
            end else if (!enable) begin
               // A button pressed outside the player's turn must be released before it can count
               stateNext = WAIT_CLEAR;
            end else if (downCount == 3'd1) begin
               numNext     = downIndex;
               pressedNext = 1'b1;
               pulseNext   = 1'b1;
               stateNext   = HELD;
            end else begin
               multiNext = 1'b1;
            end
         end
         HELD: begin
            if (!btnStable[player_num]) begin
               pressedNext = 1'b0;
               stateNext   = WAIT_CLEAR;
            end
         end
         default: begin
            pressedNext = 1'b0;
            stateNext   = WAIT_CLEAR;
         end
      endcase
   end

endmodule

// File: tb/tb_simon_button_input.sv
// Directed self-checking bench for simon_button_input with DEBOUNCE_CYCLES = 3.
// Latency: press/release checked at exactly edge 6 after the raw change.
// Backpressure: n/a.
module tb_simon_button_input;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [3:0] btn_raw;
   logic [1:0] player_num;
   logic       player_pressed;
   logic       press_pulse;
   logic       multi_press;

   int compared   = 0;
   int mismatched = 0;

   simon_button_input #(
      .DEBOUNCE_CYCLES(3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .btn_raw       (btn_raw),
      .player_num    (player_num),
      .player_pressed(player_pressed),
      .press_pulse   (press_pulse),
      .multi_press   (multi_press)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and sample 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tickN(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      enable  = 1'b0;
      btn_raw = 4'b0000;
      tickN(3);
      compared++;
      if ({player_num, player_pressed, press_pulse, multi_press} !== 5'b0) begin
         mismatched++;
         $display("FAIL reset_outputs: got %b want 00000", {player_num, player_pressed, press_pulse, multi_press});
      end
      reset = 1'b0;
      tickN(4);
   endtask

   task automatic test_single_press();
      enable  = 1'b1;
      btn_raw = 4'b0100;
      tickN(6);
      compared++;
      if ({player_pressed, press_pulse} !== 2'b00) begin
         mismatched++;
         $display("FAIL press_early: pressed/pulse %b want 00 at edge 5", {player_pressed, press_pulse});
      end
      tick();
      compared++;
      if ({player_pressed, press_pulse, player_num} !== 4'b1110) begin
         mismatched++;
         $display("FAIL press_edge6: pressed/pulse/num %b want 1110", {player_pressed, press_pulse, player_num});
      end
      tick();
      compared++;
      if ({player_pressed, press_pulse} !== 2'b10) begin
         mismatched++;
         $display("FAIL pulse_one_cycle: pressed/pulse %b want 10", {player_pressed, press_pulse});
      end
      tickN(12);
      compared++;
      if (player_pressed !== 1'b1) begin
         mismatched++;
         $display("FAIL press_held: pressed %b want 1", player_pressed);
      end
   endtask

   task automatic test_release();
      logic sawPulse;
      sawPulse = 1'b0;
      btn_raw  = 4'b0000;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (press_pulse) sawPulse = 1'b1;
      end
      compared++;
      if (player_pressed !== 1'b1) begin
         mismatched++;
         $display("FAIL release_early: pressed %b want 1 at edge 5", player_pressed);
      end
      tick();
      if (press_pulse) sawPulse = 1'b1;
      compared++;
      if ({player_pressed, player_num} !== 3'b010) begin
         mismatched++;
         $display("FAIL release_edge6: pressed/num %b want 010", {player_pressed, player_num});
      end
      compared++;
      if (sawPulse !== 1'b0) begin
         mismatched++;
         $display("FAIL release_pulse: saw pulse %b want 0", sawPulse);
      end
      tickN(3);
   endtask

   task automatic test_bounce();
      logic sawActivity;
      sawActivity = 1'b0;
      for (int i = 0; i < 10; i++) begin
         btn_raw[1] = ~btn_raw[1];
         tick();
         if (player_pressed || press_pulse || multi_press) sawActivity = 1'b1;
      end
      btn_raw = 4'b0000;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (player_pressed || press_pulse || multi_press) sawActivity = 1'b1;
      end
      compared++;
      if (sawActivity !== 1'b0) begin
         mismatched++;
         $display("FAIL bounce_quiet: activity %b want 0", sawActivity);
      end
   endtask

   task automatic test_multi_press();
      logic sawPress;
      sawPress = 1'b0;
      btn_raw  = 4'b0011;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (player_pressed || press_pulse) sawPress = 1'b1;
      end
      compared++;
      if ({multi_press, sawPress} !== 2'b10) begin
         mismatched++;
         $display("FAIL multi_flag: multi/sawPress %b want 10", {multi_press, sawPress});
      end
      btn_raw = 4'b0001;
      tickN(6);
      compared++;
      if ({multi_press, player_pressed} !== 2'b10) begin
         mismatched++;
         $display("FAIL multi_hold: multi/pressed %b want 10 at edge 5", {multi_press, player_pressed});
      end
      tick();
      compared++;
      if ({multi_press, player_pressed, press_pulse, player_num} !== 5'b01100) begin
         mismatched++;
         $display("FAIL multi_resolve: multi/pressed/pulse/num %b want 01100", {multi_press, player_pressed, press_pulse, player_num});
      end
      btn_raw = 4'b0000;
      tickN(10);
      compared++;
      if (player_pressed !== 1'b0) begin
         mismatched++;
         $display("FAIL multi_release: pressed %b want 0", player_pressed);
      end
   endtask

   task automatic test_enable_gating();
      logic sawPress;
      sawPress = 1'b0;
      enable   = 1'b0;
      btn_raw  = 4'b1000;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (player_pressed || press_pulse || multi_press) sawPress = 1'b1;
      end
      enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (player_pressed || press_pulse || multi_press) sawPress = 1'b1;
      end
      compared++;
      if (sawPress !== 1'b0) begin
         mismatched++;
         $display("FAIL enable_gate: saw press %b want 0", sawPress);
      end
      btn_raw = 4'b0000;
      tickN(8);
      btn_raw = 4'b1000;
      tickN(7);
      compared++;
      if ({player_pressed, press_pulse, player_num} !== 4'b1111) begin
         mismatched++;
         $display("FAIL enable_repress: pressed/pulse/num %b want 1111", {player_pressed, press_pulse, player_num});
      end
   endtask

   task automatic test_reset_mid_held();
      logic sawPress;
      sawPress = 1'b0;
      tickN(3);
      #3;
      reset = 1'b1;
      #1;
      compared++;
      if ({player_num, player_pressed, press_pulse, multi_press} !== 5'b0) begin
         mismatched++;
         $display("FAIL reset_async: got %b want 00000", {player_num, player_pressed, press_pulse, multi_press});
      end
      tick();
      reset = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (player_pressed || press_pulse) sawPress = 1'b1;
      end
      compared++;
      if (sawPress !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_no_accept: saw press %b want 0", sawPress);
      end
      btn_raw = 4'b0000;
      tickN(10);
      btn_raw = 4'b1000;
      tickN(7);
      compared++;
      if ({player_pressed, press_pulse, player_num} !== 4'b1111) begin
         mismatched++;
         $display("FAIL reset_repress: pressed/pulse/num %b want 1111", {player_pressed, press_pulse, player_num});
      end
      btn_raw = 4'b0000;
      tickN(10);
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_release();
      test_bounce();
      test_multi_press();
      test_enable_gating();
      test_reset_mid_held();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
